// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multi-cycle RV32M unit.
// The pipeline drives Start/Op/A/B and watches Busy/Done/Out.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            Start;
    logic [2:0]      Op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            Busy;
    logic            Done;
    logic [XLEN-1:0] Out;

    modport master (output Start, Op, A, B, input Busy, Done, Out);
    modport slave  (input Start, Op, A, B, output Busy, Done, Out);
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, sign fix-up on the way into DONE. Fixed 33-edge accept-to-Done latency.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              bzero_q, bzero_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   out_q, out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              sign_a, sign_b, take;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] mul_next, div_next, prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, result;

    // The DONE cycle doubles as an accept slot so a held Start issues every 34 edges.
    always_comb begin
        sign_a = bus.A[XLEN-1] & ~(bus.Op inside {OP_MULHU, OP_DIVU, OP_REMU});
        sign_b = bus.B[XLEN-1] & (bus.Op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
        mag_a  = sign_a ? -bus.A : bus.A;
        mag_b  = sign_b ? -bus.B : bus.B;
        take   = bus.Start & ((state_q == IDLE) | (state_q == DONE));
    end

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, opnd_q} & {(XLEN+1){acc_q[0]}});
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
        div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    // 0x80000000 / -1 needs no special path: |A|=2^31, |B|=1 and positive sign yield 0x80000000, rem 0.
    always_comb begin
        prod_s = neg_q ? -acc_q : acc_q;
        quot_s = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_s  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       result = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = bzero_q ? '1 : quot_s;
            default:                      result = rem_s;
        endcase
    end

    always_comb begin
        // NOTE: every *_d gets a default here so no path through the case can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        op_d    = op_q;
        neg_d   = neg_q;
        bzero_d = bzero_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            CALC: begin
                if (!last_q) begin
                    acc_d  = op_q[2] ? div_next : mul_next;
                    cnt_d  = cnt_q + 5'd1;
                    last_d = (cnt_q == 5'd31);
                end else begin
                    out_d   = result;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: ;
        endcase
        if (take) begin
            state_d = CALC;
            busy_d  = 1'b1;
            cnt_d   = '0;
            last_d  = 1'b0;
            op_d    = bus.Op;
            neg_d   = (bus.Op[2] & bus.Op[1]) ? sign_a : (sign_a ^ sign_b);
            bzero_d = (bus.B == '0);
            opnd_d  = bus.Op[2] ? mag_b : mag_a;
            acc_d   = {{XLEN{1'b0}}, bus.Op[2] ? mag_a : mag_b};
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            bzero_q <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            bzero_q <= bzero_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
    assign bus.Out  = out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results are queued at issue and
// popped when Done is seen; latency, Busy width and Out hold are checked per op.
module tb_muldiv_unit;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];

  muldiv_if #(.XLEN(32)) bus ();
  muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string msg);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s", msg);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      OP_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      OP_MULHSU: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = s;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expv, input bit inject);
    logic [31:0] held, want, after;
    int          busy_cnt, edges;
    bit          seen, moved;
    drive(1'b1, op, a, b);
    exp_q.push_back(expv);
    held = bus.Out;
    tick();
    busy_cnt = 0;
    edges    = 0;
    seen     = 0;
    moved    = 0;
    for (int i = 1; i <= 100 && !seen; i++) begin
      if (inject && (i == 5 || i == 33)) drive(1'b1, op ^ 3'b100, ~a, b + 32'd1);
      else drive(1'b0, 3'($urandom), $urandom, $urandom);
      if (bus.Busy) busy_cnt++;
      if (bus.Out !== held) moved = 1;
      tick();
      edges = i;
      seen  = bus.Done;
    end
    if (seen && bus.Busy) busy_cnt++;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    want = exp_q.pop_front();
    check(seen && edges == 33,
          $sformatf("%s latency: got=%0d edges (done seen=%0d) want=33", name, edges, seen));
    check(busy_cnt == 34, $sformatf("%s busy_width: got=%0d want=34", name, busy_cnt));
    check(!moved, $sformatf("%s out_hold: Out changed before Done", name));
    if (seen)
      check(bus.Out === want, $sformatf("%s result: got=%h want=%h", name, bus.Out, want));
    after = bus.Out;
    tick();
    check(bus.Done === 1'b0 && bus.Busy === 1'b0,
          $sformatf("%s pulse_end: done=%b busy=%b want 0 0", name, bus.Done, bus.Busy));
    tick();
    check(bus.Out === after, $sformatf("%s idle_hold: got=%h want=%h", name, bus.Out, after));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check(bus.Busy === 1'b0, $sformatf("reset_busy: got=%b want=0", bus.Busy));
    check(bus.Done === 1'b0, $sformatf("reset_done: got=%b want=0", bus.Done));
    check(bus.Out === 32'h0, $sformatf("reset_out: got=%h want=0", bus.Out));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check(bus.Busy === 1'b0, $sformatf("idle_no_start: busy=%b want=0", bus.Busy));
  endtask

  task automatic test_mul();
    run_op("mul_7x-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
  endtask

  task automatic test_mulh();
    run_op("mulh_min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run_op("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("mulhsu_m1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_div();
    run_op("div_-7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("rem_-7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 0);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 0);
    run_op("div_7_-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
    run_op("rem_7_-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 0);
  endtask

  task automatic test_corner();
    run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 0);
    run_op("rem_-5_0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
  endtask

  task automatic test_handshake();
    run_op("ignore_start", OP_DIVU, 32'd100, 32'd7, 32'd14, 1);
  endtask

  task automatic test_back_to_back();
    int          first, second;
    logic [31:0] want;
    drive(1'b1, OP_MUL, 32'd6, 32'd7);
    exp_q.push_back(32'd42);
    tick();
    drive(1'b1, OP_MUL, 32'h0001_0001, 32'h0001_0001);
    exp_q.push_back(32'h0002_0001);
    first  = 0;
    second = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (i == 34) begin
        check(bus.Busy === 1'b1 && bus.Done === 1'b0,
              $sformatf("b2b_accept: busy=%b done=%b want 1 0", bus.Busy, bus.Done));
        drive(1'b0, 3'b000, 32'h0, 32'h0);
      end
      if (bus.Done) begin
        if (exp_q.size() == 0) begin
          check(1'b0, $sformatf("b2b_extra_done: at edge %0d", i));
        end else begin
          want = exp_q.pop_front();
          check(bus.Out === want, $sformatf("b2b_result: got=%h want=%h", bus.Out, want));
        end
        if (first == 0) first = i;
        else if (second == 0) second = i;
      end
    end
    check(first == 33, $sformatf("b2b_first_done: got=%0d want=33", first));
    check(second == 67, $sformatf("b2b_second_done: got=%0d want=67", second));
    while (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i == 5) ? 32'h0 : $urandom >> (i * 3);
      run_op("random", 3'(i), a, b, model(3'(i), a, b), 0);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    drive(1'b1, OP_MUL, 32'h1234_5678, 32'd9);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    repeat (9) tick();
    #2 rst_n = 1'b0;
    #1;
    check(bus.Busy === 1'b0, $sformatf("rst_mid_busy: got=%b want=0", bus.Busy));
    check(bus.Done === 1'b0, $sformatf("rst_mid_done: got=%b want=0", bus.Done));
    check(bus.Out === 32'h0, $sformatf("rst_mid_out: got=%h want=0", bus.Out));
    drive(1'b1, OP_MUL, 32'd3, 32'd4);
    nd = 0;
    repeat (3) begin
      tick();
      if (bus.Done) nd++;
    end
    check(nd == 0, $sformatf("rst_mid_no_done: got=%0d done pulses want=0", nd));
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_reset_mul", OP_MUL, 32'd3, 32'd4, 32'd12, 0);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_corner();
    test_handshake();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
